// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: instruction field layout,
// class encodings, FSM states and the per-stage scoreboard slot.
package hazard_pkg;

  localparam int INSTR_W = 19;
  localparam int REG_W   = 3;

  localparam int RD_LSB = 11;
  localparam int RS_LSB = 8;
  localparam int RT_LSB = 5;

  localparam logic [1:0] CLS_RREG   = 2'b00;
  localparam logic [1:0] CLS_RIMM   = 2'b01;
  localparam logic [2:0] CLS_SHIFT  = 3'b110;
  localparam logic [2:0] CLS_MEM    = 3'b100;
  localparam logic [2:0] CLS_BRANCH = 3'b101;
  localparam logic [3:0] CLS_JMP    = 4'b1110;
  localparam logic [5:0] CLS_RET    = 6'b111100;

  localparam logic [1:0] MEM_LOAD  = 2'b00;
  localparam logic [1:0] MEM_STORE = 2'b01;

  localparam logic [INSTR_W-1:0] HALT = '1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_t;

  typedef struct packed {
    logic             valid;
    logic             writes;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } slot_t;

  // R0 is hardwired zero, so it can never be the subject of a hazard.
  function automatic logic src_hit(logic uses, logic [REG_W-1:0] src, slot_t s);
    return uses && (src != '0) && s.valid && s.writes && (s.rd == src);
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_if
  import hazard_pkg::*;
#(
  parameter int IW  = INSTR_W,
  parameter int SCW = 16
);
  logic [IW-1:0]  id_instr;
  logic           id_valid;
  logic           ex_branch_taken;
  logic           pc_write;
  logic           if_id_write;
  logic           if_id_flush;
  logic           id_ex_bubble;
  logic [1:0]     fwd_a;
  logic [1:0]     fwd_b;
  logic           halted;
  logic [SCW-1:0] stall_cycles;

  modport master (
    output id_instr, id_valid, ex_branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
    input  fwd_a, fwd_b, halted, stall_cycles
  );

  modport slave (
    input  id_instr, id_valid, ex_branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
    output fwd_a, fwd_b, halted, stall_cycles
  );
endinterface

// File: rtl/hazard_decode.sv
// Maps one instruction word to its register reads, register write and load/halt flags.
module hazard_decode
  import hazard_pkg::*;
#(
  parameter int IW = INSTR_W,
  parameter int RW = REG_W
) (
  input  logic [IW-1:0] instr,
  output logic [RW-1:0] src_a,
  output logic [RW-1:0] src_b,
  output logic          uses_a,
  output logic          uses_b,
  output logic          writes,
  output logic [RW-1:0] rd,
  output logic          is_load,
  output logic          is_halt
);

  always_comb begin
    // NOTE: every output gets a default first so no decode path infers a latch.
    src_a   = instr[RS_LSB +: RW];
    src_b   = instr[RT_LSB +: RW];
    rd      = instr[RD_LSB +: RW];
    uses_a  = 1'b0;
    uses_b  = 1'b0;
    writes  = 1'b0;
    is_load = 1'b0;
    is_halt = 1'b0;

    if (instr == HALT) begin
      is_halt = 1'b1;
    end else if (instr[IW-1 -: 2] == CLS_RREG) begin
      uses_a = 1'b1;
      uses_b = 1'b1;
      writes = 1'b1;
    end else if (instr[IW-1 -: 2] == CLS_RIMM || instr[IW-1 -: 3] == CLS_SHIFT) begin
      uses_a = 1'b1;
      writes = 1'b1;
    end else if (instr[IW-1 -: 3] == CLS_MEM) begin
      if (instr[IW-4 -: 2] == MEM_LOAD) begin
        uses_a  = 1'b1;
        writes  = 1'b1;
        is_load = 1'b1;
      end else if (instr[IW-4 -: 2] == MEM_STORE) begin
        // The store data register sits in the rd field and feeds operand B.
        uses_a = 1'b1;
        uses_b = 1'b1;
        src_b  = instr[RD_LSB +: RW];
      end
    end else if (instr[IW-1 -: 3] == CLS_BRANCH || instr[IW-1 -: 4] == CLS_JMP ||
                 instr[IW-1 -: 6] == CLS_RET) begin
      // Control transfers neither read nor write the register file.
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall, taken-transfer flush, EX forwarding selects and halt drain for the
// 5-stage core, driven from a private EX/MEM/WB scoreboard.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int IW  = INSTR_W,
  parameter int RW  = REG_W,
  parameter int SCW = 16
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);

  logic [RW-1:0] src_a, src_b, id_rd;
  logic          uses_a, uses_b, id_writes, id_is_load, id_is_halt;

  hazard_decode #(.IW(IW), .RW(RW)) u_decode (
    .instr   (hz.id_instr),
    .src_a   (src_a),
    .src_b   (src_b),
    .uses_a  (uses_a),
    .uses_b  (uses_b),
    .writes  (id_writes),
    .rd      (id_rd),
    .is_load (id_is_load),
    .is_halt (id_is_halt)
  );

  state_t         state, next_state;
  slot_t          ex_s, mem_s, wb_s, id_slot;
  fwd_t           fwd_a, fwd_b;
  logic [SCW-1:0] stall_cnt;
  logic           pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic           load_use, halt_req, slots_empty, issue;

  assign load_use = hz.id_valid && ex_s.is_load &&
                    (src_hit(uses_a, src_a, ex_s) || src_hit(uses_b, src_b, ex_s));
  assign halt_req    = hz.id_valid && id_is_halt;
  assign slots_empty = !(ex_s.valid || mem_s.valid || wb_s.valid);
  assign issue       = hz.id_valid && !id_ex_bubble;
  assign id_slot     = '{valid: 1'b1, writes: id_writes, rd: id_rd, is_load: id_is_load};

  function automatic fwd_t fwd_sel(logic uses, logic [RW-1:0] src);
    if (src_hit(uses, src, ex_s))  return FWD_EXMEM;
    if (src_hit(uses, src, mem_s)) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  // Pipeline controls hold low for the whole time rst is high.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    next_state   = state;
    if (!rst) begin
      case (state)
        RUN: begin
          if (hz.ex_branch_taken) begin
            {pc_write, if_id_write, if_id_flush, id_ex_bubble} = 4'b1111;
          end else if (halt_req) begin
            id_ex_bubble = 1'b1;
            next_state   = DRAIN;
          end else if (load_use) begin
            id_ex_bubble = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        DRAIN: begin
          if (hz.ex_branch_taken) begin
            {pc_write, if_id_write, if_id_flush, id_ex_bubble} = 4'b1111;
            next_state = RUN;
          end else begin
            id_ex_bubble = 1'b1;
            if (slots_empty) next_state = HALTED;
          end
        end
        default: id_ex_bubble = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the scoreboard slots are cleared explicitly so no stale producer survives a reset.
      state     <= RUN;
      ex_s      <= '0;
      mem_s     <= '0;
      wb_s      <= '0;
      fwd_a     <= FWD_RF;
      fwd_b     <= FWD_RF;
      stall_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      state <= next_state;
      wb_s  <= mem_s;
      mem_s <= ex_s;
      ex_s  <= issue ? id_slot : '0;
      fwd_a <= issue ? fwd_sel(uses_a, src_a) : FWD_RF;
      fwd_b <= issue ? fwd_sel(uses_b, src_b) : FWD_RF;
      if (!pc_write && state != HALTED && stall_cnt != '1)
        stall_cnt <= stall_cnt + SCW'(1);
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.fwd_a        = fwd_a;
  assign hz.fwd_b        = fwd_b;
  assign hz.halted       = (state == HALTED);
  assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized bench for hazard_unit: a cycle-level reference model of the pipe checks
// every output each cycle, and directed sequences pin the model with literal values.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int SCW = 4;
  localparam int SAT = (1 << SCW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_if #(.IW(INSTR_W), .SCW(SCW)) hz ();

  hazard_unit #(.IW(INSTR_W), .RW(REG_W), .SCW(SCW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction builders
  function automatic logic [18:0] mk_r(input logic [2:0] fn, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt);
    return {2'b00, fn, rd, rs, rt, 5'b0};
  endfunction
  function automatic logic [18:0] mk_ld(input logic [2:0] rd, input logic [2:0] rs,
                                        input logic [7:0] imm);
    return {3'b100, 2'b00, rd, rs, imm};
  endfunction

  function automatic logic [18:0] rand_instr();
    logic [2:0] rd, rs, rt;
    int k;
    rd = 3'($urandom_range(0, 3));
    rs = 3'($urandom_range(0, 3));
    rt = 3'($urandom_range(0, 3));
    k  = $urandom_range(0, 39);
    if (k < 10)      return mk_r(3'($urandom), rd, rs, rt);
    else if (k < 14) return {2'b01, 3'($urandom), rd, rs, 8'($urandom)};
    else if (k < 16) return {3'b110, 2'b00, rd, rs, 8'($urandom)};
    else if (k < 24) return mk_ld(rd, rs, 8'($urandom));
    else if (k < 28) return {3'b100, 2'b01, rd, rs, 8'($urandom)};
    else if (k < 30) return {3'b101, 16'($urandom)};
    else if (k < 32) return {4'b1110, 15'($urandom)};
    else if (k < 33) return {6'b111100, 13'($urandom)};
    else if (k < 34) return '1;
    else             return 19'($urandom);
  endfunction

  // ---------------- reference model ----------------
  typedef enum {M_RUN, M_DRAIN, M_HALT} mmode_t;
  typedef struct {bit busy; int dst; bit load;} mslot_t;

  mmode_t m_mode;
  mslot_t m_pipe[$];   // [0]=EX, [1]=MEM, [2]=WB
  int     m_fwd_a, m_fwd_b, m_stall;

  // dst/sa/sb of 0 mean "none": R0 never matters for hazards.
  task automatic mdecode(input logic [18:0] i, output int dst, output int sa,
                         output int sb, output bit ld, output bit hlt);
    dst = 0; sa = 0; sb = 0; ld = 0; hlt = 0;
    if (i == '1) hlt = 1;
    else begin
      casez (i[18:13])
        6'b00????: begin dst = i[13:11]; sa = i[10:8]; sb = i[7:5]; end
        6'b01????, 6'b110???: begin dst = i[13:11]; sa = i[10:8]; end
        6'b100???: begin
          if (i[15:14] == 2'b00) begin dst = i[13:11]; sa = i[10:8]; ld = 1; end
          else if (i[15:14] == 2'b01) begin sa = i[10:8]; sb = i[13:11]; end
        end
        default: ;
      endcase
    end
  endtask

  function automatic int nearest(input int s);
    if (s == 0) return 0;
    if (m_pipe[0].busy && m_pipe[0].dst == s) return 1;
    if (m_pipe[1].busy && m_pipe[1].dst == s) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin : model
    int dst, sa, sb;
    bit ld, hlt, lu, issue, empty;
    bit e_pc, e_ifid, e_fl, e_bub;
    mslot_t nx;
    if (rst) begin
      check("rst_pc_write", hz.pc_write, 0);
      check("rst_if_id_write", hz.if_id_write, 0);
      check("rst_if_id_flush", hz.if_id_flush, 0);
      check("rst_id_ex_bubble", hz.id_ex_bubble, 0);
      check("rst_fwd_a", hz.fwd_a, 0);
      check("rst_fwd_b", hz.fwd_b, 0);
      check("rst_halted", hz.halted, 0);
      check("rst_stall_cycles", hz.stall_cycles, 0);
      m_mode = M_RUN;
      m_pipe.delete();
      repeat (3) m_pipe.push_back('{busy: 0, dst: 0, load: 0});
      m_fwd_a = 0; m_fwd_b = 0; m_stall = 0;
    end else begin
      mdecode(hz.id_instr, dst, sa, sb, ld, hlt);
      lu = hz.id_valid && m_pipe[0].busy && m_pipe[0].load && m_pipe[0].dst != 0 &&
           (m_pipe[0].dst == sa || m_pipe[0].dst == sb);
      empty = !(m_pipe[0].busy || m_pipe[1].busy || m_pipe[2].busy);
      if (m_mode == M_HALT)
        {e_pc, e_ifid, e_fl, e_bub} = 4'b0001;
      else if (hz.ex_branch_taken)
        {e_pc, e_ifid, e_fl, e_bub} = 4'b1111;
      else if (m_mode == M_DRAIN || (hz.id_valid && hlt) || lu)
        {e_pc, e_ifid, e_fl, e_bub} = 4'b0001;
      else
        {e_pc, e_ifid, e_fl, e_bub} = 4'b1100;

      check("pc_write", hz.pc_write, e_pc);
      check("if_id_write", hz.if_id_write, e_ifid);
      check("if_id_flush", hz.if_id_flush, e_fl);
      check("id_ex_bubble", hz.id_ex_bubble, e_bub);
      check("fwd_a", hz.fwd_a, m_fwd_a);
      check("fwd_b", hz.fwd_b, m_fwd_b);
      check("halted", hz.halted, (m_mode == M_HALT) ? 1 : 0);
      check("stall_cycles", hz.stall_cycles, m_stall);

      issue   = hz.id_valid && !e_bub;
      m_fwd_a = issue ? nearest(sa) : 0;
      m_fwd_b = issue ? nearest(sb) : 0;
      if (!e_pc && m_mode != M_HALT && m_stall < SAT) m_stall++;
      if (m_mode == M_RUN) begin
        if (!hz.ex_branch_taken && hz.id_valid && hlt) m_mode = M_DRAIN;
      end else if (m_mode == M_DRAIN) begin
        if (hz.ex_branch_taken) m_mode = M_RUN;
        else if (empty)         m_mode = M_HALT;
      end
      nx = '{busy: issue, dst: issue ? dst : 0, load: issue && ld};
      m_pipe.push_front(nx);
      void'(m_pipe.pop_back());
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [18:0] i, input logic v, input logic b, input logic r = 1'b0);
    @(posedge clk);
    #1;
    hz.id_instr        = i;
    hz.id_valid        = v;
    hz.ex_branch_taken = b;
    rst                = r;
    @(negedge clk);
  endtask

  localparam logic [18:0] NOP = '0;

  initial begin
    logic [18:0] cur_i;
    logic        cur_v;
    int          halted_for;
    int          first;

    hz.id_instr = '0;
    hz.id_valid = 1'b0;
    hz.ex_branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    check("init_halted", hz.halted, 0);
    cyc(NOP, 0, 0);
    check("post_rst_pc_write", hz.pc_write, 1);
    check("post_rst_if_id_write", hz.if_id_write, 1);

    // Load-use: one bubble, consumer forwards from MEM/WB.
    cyc(mk_ld(3'd3, 3'd1, 8'd4), 1, 0);
    check("lu_ld_pc_write", hz.pc_write, 1);
    cyc(mk_r(3'd0, 3'd4, 3'd3, 3'd2), 1, 0);
    check("lu_stall_pc_write", hz.pc_write, 0);
    check("lu_stall_bubble", hz.id_ex_bubble, 1);
    cyc(mk_r(3'd0, 3'd4, 3'd3, 3'd2), 1, 0);
    check("lu_resume_pc_write", hz.pc_write, 1);
    check("lu_stall_cycles", hz.stall_cycles, 1);
    cyc(NOP, 0, 0);
    check("lu_fwd_a", hz.fwd_a, 2'b10);
    check("lu_fwd_b", hz.fwd_b, 2'b00);

    // ALU back-to-back: both operands from EX/MEM.
    cyc(mk_r(3'd0, 3'd3, 3'd1, 3'd2), 1, 0);
    cyc(mk_r(3'd1, 3'd5, 3'd3, 3'd3), 1, 0);
    check("alu_no_stall", hz.pc_write, 1);
    cyc(NOP, 0, 0);
    check("alu_fwd_a", hz.fwd_a, 2'b01);
    check("alu_fwd_b", hz.fwd_b, 2'b01);

    // Two producers of R3: nearest wins.
    cyc(mk_r(3'd0, 3'd3, 3'd1, 3'd2), 1, 0);
    cyc(mk_r(3'd0, 3'd3, 3'd2, 3'd2), 1, 0);
    cyc(mk_r(3'd2, 3'd6, 3'd3, 3'd1), 1, 0);
    cyc(NOP, 0, 0);
    check("near_fwd_a", hz.fwd_a, 2'b01);
    check("near_fwd_b", hz.fwd_b, 2'b00);

    // Taken transfer overrides a load-use condition.
    cyc(mk_ld(3'd3, 3'd1, 8'd4), 1, 0);
    cyc(mk_r(3'd0, 3'd4, 3'd3, 3'd2), 1, 1);
    check("br_flush", hz.if_id_flush, 1);
    check("br_bubble", hz.id_ex_bubble, 1);
    check("br_pc_write", hz.pc_write, 1);
    check("br_if_id_write", hz.if_id_write, 1);
    cyc(NOP, 0, 0);
    check("br_no_stall_count", hz.stall_cycles, 1);

    // R0 never hazards.
    cyc(mk_ld(3'd0, 3'd1, 8'd4), 1, 0);
    cyc(mk_r(3'd0, 3'd4, 3'd0, 3'd0), 1, 0);
    check("r0_no_stall", hz.pc_write, 1);
    cyc(NOP, 0, 0);
    check("r0_fwd_a", hz.fwd_a, 0);
    check("r0_fwd_b", hz.fwd_b, 0);

    // Halt, then a taken transfer during DRAIN cancels it.
    cyc(mk_r(3'd0, 3'd1, 3'd2, 3'd2), 1, 0);
    cyc(mk_r(3'd0, 3'd2, 3'd1, 3'd1), 1, 0);
    cyc('1, 1, 0);
    check("halt_enter_pc_write", hz.pc_write, 0);
    check("halt_enter_bubble", hz.id_ex_bubble, 1);
    cyc('1, 1, 1);
    check("drain_br_flush", hz.if_id_flush, 1);
    check("drain_br_pc_write", hz.pc_write, 1);
    cyc(NOP, 0, 0);
    check("drain_br_not_halted", hz.halted, 0);
    check("drain_br_run_pc_write", hz.pc_write, 1);

    // Halt behind two ALU ops reaches halted within 4 cycles.
    cyc(mk_r(3'd0, 3'd1, 3'd2, 3'd2), 1, 0);
    cyc(mk_r(3'd0, 3'd2, 3'd1, 3'd1), 1, 0);
    cyc('1, 1, 0);
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc('1, 1, 0);
      if (hz.halted && first == 0) first = k;
    end
    check("halt_latency_le4", (first >= 1 && first <= 4) ? 1 : 0, 1);
    check("halted_sticky", hz.halted, 1);
    check("halted_pc_write", hz.pc_write, 0);
    cyc('1, 1, 0, 1);
    check("rst_in_halted_halted", hz.halted, 0);
    check("rst_in_halted_stall", hz.stall_cycles, 0);
    check("rst_in_halted_bubble", hz.id_ex_bubble, 0);
    cyc(NOP, 0, 0);
    check("after_rst_pc_write", hz.pc_write, 1);

    // Saturation of the stall counter.
    for (int n = 0; n < 20; n++) begin
      cyc(mk_ld(3'd3, 3'd1, 8'd0), 1, 0);
      cyc(mk_r(3'd0, 3'd4, 3'd3, 3'd2), 1, 0);
      cyc(mk_r(3'd0, 3'd4, 3'd3, 3'd2), 1, 0);
    end
    check("stall_saturated", hz.stall_cycles, SAT);

    // Reset mid-DRAIN.
    cyc(mk_r(3'd0, 3'd1, 3'd2, 3'd2), 1, 0);
    cyc('1, 1, 0);
    cyc('1, 1, 0, 1);
    check("mid_drain_rst_stall", hz.stall_cycles, 0);
    cyc(NOP, 0, 0);
    check("mid_drain_rst_pc_write", hz.pc_write, 1);
    check("mid_drain_rst_halted", hz.halted, 0);

    // Randomized traffic with pipeline-like hold/flush behaviour.
    cur_i = NOP;
    cur_v = 1'b0;
    halted_for = 0;
    for (int n = 0; n < 4000; n++) begin
      logic do_rst;
      if (hz.halted) halted_for++; else halted_for = 0;
      do_rst = (halted_for > 3) || ($urandom_range(0, 299) == 0);
      if (hz.if_id_flush) begin
        cur_v = 1'b0;
      end else if (hz.if_id_write) begin
        cur_i = rand_instr();
        cur_v = ($urandom_range(0, 7) != 0);
      end
      cyc(cur_i, cur_v, ($urandom_range(0, 9) == 0), do_rst);
    end

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and sequencing controller for the 5-stage 19-bit-instruction core (IF, ID, EX, MEM, WB). It sits beside the decode controller and keeps its own scoreboard of the instructions in EX, MEM and WB. From that scoreboard it stalls on load-use, flushes on taken control transfers, and produces registered forwarding selects for the EX operand muxes. It also drains the pipe on a halt instruction and then latches `halted`.

## Interface
Parameters:
- `IW`, 19: instruction width.
- `RW`, 3: register index width (8 registers, R0 hardwired zero).
- `SCW`, 16: stall-cycle counter width.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `id_instr`  in  IW  instruction held in the IF/ID register.
- `id_valid`  in  1  `id_instr` is a real instruction (0 = nop/bubble).
- `ex_branch_taken`  in  1  instruction in EX redirects the PC (taken beq-class, jmp, jsb or ret).
- `pc_write`  out  1  PC may load its next value.
- `if_id_write`  out  1  IF/ID register may load.
- `if_id_flush`  out  1  IF/ID register loads a nop on this edge.
- `id_ex_bubble`  out  1  ID/EX register loads a nop on this edge.
- `fwd_a`, `fwd_b`  out  2  EX operand select: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write data.
- `halted`  out  1  pipe drained after a halt; sticky.
- `stall_cycles`  out  SCW  saturating count of cycles with `pc_write`=0 while not halted.

## Operation
Instruction decode fields:
- class: [18:17]=00 R-reg, 01 R-imm; [18:16]=110 shift, 100 memory ([15:14]=00 load, 01 store), 101 branch; [18:15]=1110 jmp/jsb; [18:13]=111100 ret.
- halt is all ones.
- registers: rd=[13:11], rs=[10:8], rt=[7:5].

Register usage by class:
- R-reg: reads rs and rt, writes rd.
- R-imm and shift: read rs, write rd.
- load: reads rs, writes rd.
- store: reads rs, and reads [13:11] as the B operand.
- branch, jmp, jsb, ret, halt: no register reads or writes.
- A source or destination equal to R0 never creates a hazard.

Scoreboard:
- Three slots, EX, MEM and WB. Each slot holds {valid, writes, rd, is_load}.
- Every edge: WB←MEM, MEM←EX.
- EX←decoded `id_instr` if `id_valid` and `id_ex_bubble`=0; otherwise EX←invalid.

Load-use stall:
- Condition: an ID source matches a valid is_load EX slot rd.
- Response: `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1 for exactly one cycle.

Forwarding:
- Computed per source against the EX and MEM slots and registered on the edge that moves the instruction into EX.
- Match in EX slot → 01. Match in MEM slot → 10. EX slot has priority over MEM.
- A match in the WB slot needs no forwarding: the register file is write-before-read.
- During a bubble, the registered selects are 00.

Flush:
- On `ex_branch_taken`=1: `if_id_flush`=1, `id_ex_bubble`=1, `pc_write`=1, `if_id_write`=1.
- Flush overrides stall and halt detection in the same cycle.

FSM:
- RUN:
  - halt in ID with `id_valid` and no flush → DRAIN.
  - While entering and in DRAIN: `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1; the halt never enters the EX slot.
- DRAIN:
  - `ex_branch_taken` → RUN, with the flush response (the halt was speculative).
  - All three slots invalid → HALTED.
- HALTED: `halted`=1, `pc_write`=`if_id_write`=0, `id_ex_bubble`=1; exits only via `rst`.

## Timing
- `rst` high: state RUN, all slots invalid. Every output is 0: `fwd_a`, `fwd_b`, `halted`, `stall_cycles`, `pc_write`, `if_id_write`, `if_id_flush`, `id_ex_bubble`.
- First cycle after `rst` falls: `pc_write`=`if_id_write`=1.
- `pc_write`, `if_id_write`, `if_id_flush`, `id_ex_bubble` are combinational from state, scoreboard, `id_instr` and `ex_branch_taken`. They are valid in the same cycle, before the edge.
- `fwd_a`, `fwd_b`, `halted`, `stall_cycles` are registered.
- Load-use costs exactly 1 bubble. The consumer then forwards with 10.
- Taken transfer costs 2 killed slots (IF and ID).
- Halt to `halted`: at most 4 cycles (3 drain cycles plus 1 transition cycle).
- `stall_cycles` saturates at all-ones and never wraps.
- Reset asserted mid-DRAIN or mid-stall takes effect immediately; nothing is retained.

## Structure
- `hazard_pkg` contains:
  - opcode/class constants and field bit positions;
  - the HALT encoding;
  - the state enum {RUN, DRAIN, HALTED};
  - the slot struct {valid, writes, rd, is_load}.
- One combinational sub-module, `hazard_decode`, maps an instruction to {src_a, src_b, uses_a, uses_b, writes, rd, is_load, is_halt}. It is instantiated once, for `id_instr`.

## Test plan
- Load R3←[R1+4], then add R4←R3+R2 back-to-back → one cycle with `pc_write`=0, `id_ex_bubble`=1; add enters EX with `fwd_a`=10, `fwd_b`=00; `stall_cycles`=1.
- add R3←R1+R2, then sub R5←R3−R3 → no stall; sub in EX shows `fwd_a`=`fwd_b`=01.
- add R3, add R3, then or R6←R3|R1 → or uses `fwd_a`=01 (nearest producer wins).
- `ex_branch_taken`=1 while a load-use condition exists in ID → `if_id_flush`=1, `id_ex_bubble`=1, `pc_write`=1; no stall counted.
- Load to R0, then add using R0 → no stall, forwarding selects 00.
- Halt in ID behind two ALU instructions → DRAIN, `halted`=1 within 4 cycles. Repeat with `ex_branch_taken`=1 during DRAIN → back to RUN with `halted`=0. Asserting `rst` in HALTED → all outputs 0.
